// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT input framer and its frame banks.
package fft_pkg;

    localparam int SAMPLE_W = 8;
    localparam int FFT_N    = 4;
    localparam int IDX_W    = 2;

    // Issue-side state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } issue_state_t;

    // Next slot index within a frame; wraps 3 -> 0.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer: four sample registers with a single-slot write port,
// a zero-pad port that clears every slot from a given index upward, and a
// parallel read port.
module fft_frame_bank #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        wr_en,
    input  logic [fft_pkg::IDX_W-1:0]                   wr_idx,
    input  logic [SAMPLE_W-1:0]                         wr_data,
    input  logic                                        pad_en,
    input  logic [fft_pkg::IDX_W-1:0]                   pad_idx,
    output logic [fft_pkg::FFT_N-1:0][SAMPLE_W-1:0]     rd_data
);
    import fft_pkg::*;

    logic [FFT_N-1:0][SAMPLE_W-1:0] mem_r;

    // Per-slot update: a write wins; padding only touches slots above the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_r <= '0;
        end else begin
            for (int i = 0; i < FFT_N; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    mem_r[i] <= wr_data;
                end else if (pad_en && (IDX_W'(i) >= pad_idx)) begin
                    mem_r[i] <= '0;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    assign rd_data = mem_r;

endmodule

// File: rtl/fft_input_framer.sv
// Packs a valid/ready sample stream into 4-sample frames using two ping-pong
// banks and issues each frame to the FFT with a held start strobe.
module fft_input_framer #(
    parameter int SAMPLE_W     = fft_pkg::SAMPLE_W,
    parameter int START_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [SAMPLE_W-1:0] x0,
    output logic [SAMPLE_W-1:0] x1,
    output logic [SAMPLE_W-1:0] x2,
    output logic [SAMPLE_W-1:0] x3,
    output logic                start,
    output logic                busy,
    output logic [CNT_W-1:0]    frame_count
);
    import fft_pkg::*;

    localparam logic [3:0] CNT_LAST = 4'(START_CYCLES - 1);

    logic [1:0]                     full_r;
    logic [1:0]                     full_nxt_s;
    logic                           wr_bank_r;
    logic                           wr_bank_nxt_s;
    logic [IDX_W-1:0]               wr_idx_r;
    logic [IDX_W-1:0]               wr_idx_nxt_s;
    logic [IDX_W-1:0]               idx_after_s;
    logic                           rd_bank_r;
    logic                           in_ready_r;
    logic                           accept_s;
    logic                           completed_s;
    logic                           flush_s;
    logic                           close_s;
    logic                           release_s;
    issue_state_t                   state_r;
    logic [3:0]                     cnt_r;
    logic                           start_r;
    logic                           busy_r;
    logic [CNT_W-1:0]               frame_count_r;
    logic [FFT_N-1:0][SAMPLE_W-1:0] frame_r;
    logic [FFT_N-1:0][SAMPLE_W-1:0] bank0_rd_s;
    logic [FFT_N-1:0][SAMPLE_W-1:0] bank1_rd_s;
    logic [FFT_N-1:0][SAMPLE_W-1:0] bank_rd_s;

    // Write-side decode: accept, frame completion, flush and full-flag next state.
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        completed_s = accept_s && (wr_idx_r == 2'd3);
        idx_after_s = accept_s ? idx_inc(wr_idx_r) : wr_idx_r;
        flush_s     = flush && !completed_s && (idx_after_s != 2'd0);
        close_s     = completed_s || flush_s;
        release_s   = (state_r == ST_ISSUE) && (cnt_r == CNT_LAST);
        for (int b = 0; b < 2; b++) begin
            full_nxt_s[b] = (full_r[b] && !(release_s && (rd_bank_r == 1'(b))))
                          || (close_s && (wr_bank_r == 1'(b)));
        end
        wr_bank_nxt_s = close_s ? ~wr_bank_r : wr_bank_r;
        wr_idx_nxt_s  = close_s ? 2'd0 : idx_after_s;
        bank_rd_s     = rd_bank_r ? bank1_rd_s : bank0_rd_s;
    end

    fft_frame_bank #(.SAMPLE_W(SAMPLE_W)) u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept_s && (wr_bank_r == 1'b0)),
        .wr_idx  (wr_idx_r),
        .wr_data (in_data),
        .pad_en  (flush_s && (wr_bank_r == 1'b0)),
        .pad_idx (idx_after_s),
        .rd_data (bank0_rd_s)
    );

    fft_frame_bank #(.SAMPLE_W(SAMPLE_W)) u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept_s && (wr_bank_r == 1'b1)),
        .wr_idx  (wr_idx_r),
        .wr_data (in_data),
        .pad_en  (flush_s && (wr_bank_r == 1'b1)),
        .pad_idx (idx_after_s),
        .rd_data (bank1_rd_s)
    );

    // Write pointer, full flags and registered ready (no path from in_valid).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_r     <= 2'b00;
            wr_bank_r  <= 1'b0;
            wr_idx_r   <= 2'd0;
            in_ready_r <= 1'b0;
        end else begin
            full_r     <= full_nxt_s;
            wr_bank_r  <= wr_bank_nxt_s;
            wr_idx_r   <= wr_idx_nxt_s;
            in_ready_r <= !full_nxt_s[wr_bank_nxt_s];
        end
    end

    // Issue FSM: load a full bank, hold start, release the bank, force a low gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            rd_bank_r     <= 1'b0;
            frame_count_r <= '0;
            frame_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (full_r[rd_bank_r]) begin
                        frame_r <= bank_rd_s;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                        cnt_r   <= 4'd0;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (release_s) begin
                        rd_bank_r     <= ~rd_bank_r;
                        frame_count_r <= frame_count_r + 1'b1;
                        start_r       <= 1'b0;
                        state_r       <= ST_GAP;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_GAP: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign x0          = frame_r[0];
    assign x1          = frame_r[1];
    assign x2          = frame_r[2];
    assign x3          = frame_r[3];
    assign start       = start_r;
    assign busy        = busy_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench for fft_input_framer: table-driven frames feeding a
// scoreboard queue, plus directed stall, flush, reset, wrap and pulse cases.
module tb_fft_input_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [7:0]  x0, x1, x2, x3;
    logic        start;
    logic        busy;
    logic [15:0] frame_count;

    logic [7:0]  in_data1;
    logic        in_valid1;
    logic        in_ready1;
    logic        flush1;
    logic [7:0]  y0, y1, y2, y3;
    logic        start1;
    logic        busy1;
    logic [15:0] frame_count1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_fc = 16'd0;
    int          hi_cnt = 0;
    logic        start_prev = 1'b0;
    int          stall_cnt = 0;

    always #5 clk = ~clk;

    fft_input_framer #(.SAMPLE_W(8), .START_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .start(start), .busy(busy), .frame_count(frame_count)
    );

    fft_input_framer #(.SAMPLE_W(8), .START_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .flush(flush1), .x0(y0), .x1(y1), .x2(y2), .x3(y3),
        .start(start1), .busy(busy1), .frame_count(frame_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop a frame at each start rise, check strobe length and count at its fall.
    always @(negedge clk) begin
        if (!reset_n) begin
            hi_cnt     = 0;
            start_prev = 1'b0;
        end else begin
            if (start && !start_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {x0, x1, x2, x3}, 32'hxxxxxxxx);
                end else begin
                    check("frame", {x0, x1, x2, x3}, exp_q.pop_front());
                end
                check("busy_on_start", {31'd0, busy}, 32'd1);
                hi_cnt = 1;
            end else if (start) begin
                hi_cnt++;
            end else if (start_prev) begin
                check("start_len", hi_cnt, 32'd2);
                exp_fc = exp_fc + 16'd1;
                check("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
            end
            start_prev = start;
        end
    end

    task automatic send(input logic [7:0] d, input logic fl);
        int guard;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        flush    = fl;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            stall_cnt++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || start || busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] s;
        int          n;
        bit          fl;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int hi1;
        logic [31:0] f1;
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        in_data1  = 8'h00;
        in_valid1 = 1'b0;
        flush1    = 1'b0;

        vecs[0] = '{s: 32'h01020304, n: 4, fl: 1'b0, exp: 32'h01020304};
        vecs[1] = '{s: 32'hAABB0000, n: 2, fl: 1'b1, exp: 32'hAABB0000};
        vecs[2] = '{s: 32'h11223355, n: 4, fl: 1'b1, exp: 32'h11223355};
        vecs[3] = '{s: 32'h77000000, n: 1, fl: 1'b1, exp: 32'h77000000};

        // Reset state.
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_x", {x0, x1, x2, x3}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Table-driven frames, including flush of a partial and flush on completion.
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(vecs[v].exp);
            for (int j = 0; j < vecs[v].n; j++) begin
                send(vecs[v].s[31-8*j -: 8], vecs[v].fl && (j == vecs[v].n - 1));
            end
            idle();
            drain();
        end
        check("count_after_table", {16'd0, frame_count}, 32'd4);

        // Flush with an empty buffer issues nothing.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
        check("empty_flush_count", {16'd0, frame_count}, 32'd4);
        check("empty_flush_start", {31'd0, start}, 32'd0);

        // Back-to-back 12 samples with in_valid held high.
        exp_q.push_back(32'h10111213);
        exp_q.push_back(32'h14151617);
        exp_q.push_back(32'h18191A1B);
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), 1'b0);
        idle();
        drain();
        check("count_after_b2b", {16'd0, frame_count}, 32'd7);

        // One-sample flushed frames each cycle: both banks fill, ready must drop.
        stall_cnt = 0;
        exp_q.push_back(32'h21000000);
        exp_q.push_back(32'h22000000);
        exp_q.push_back(32'h23000000);
        send(8'h21, 1'b1);
        send(8'h22, 1'b1);
        send(8'h23, 1'b1);
        idle();
        drain();
        check("stall_seen", {31'd0, (stall_cnt != 0)}, 32'd1);
        check("count_after_stall", {16'd0, frame_count}, 32'd10);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.frame_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_r;
        exp_fc = 16'hFFFF;
        exp_q.push_back(32'h31323334);
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b0);
        idle();
        drain();
        check("wrap_count", {16'd0, frame_count}, 32'd0);

        // Reset while start is high, with a partial frame pending.
        exp_q.push_back(32'h41424344);
        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        idle();
        begin
            int g;
            g = 0;
            while (!start && g < 20) begin
                @(negedge clk);
                g++;
            end
            check("start_before_reset", {31'd0, start}, 32'd1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_start", {31'd0, start}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        exp_q.delete();
        exp_fc = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_stale_frame", {31'd0, start}, 32'd0);
        exp_q.push_back(32'hC1C2C3C4);
        for (int i = 0; i < 4; i++) send(8'hC1 + 8'(i), 1'b0);
        idle();
        drain();
        check("count_after_midrst", {16'd0, frame_count}, 32'd1);

        // START_CYCLES=1 instance: start is a single-cycle pulse.
        check("p1_ready", {31'd0, in_ready1}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data1  = 8'h91 + 8'(i);
            in_valid1 = 1'b1;
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        hi1 = 0;
        f1  = 32'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (start1) begin
                hi1++;
                f1 = {y0, y1, y2, y3};
            end
        end
        check("p1_start_len", hi1, 32'd1);
        check("p1_frame", f1, 32'h91929394);
        check("p1_frame_count", {16'd0, frame_count1}, 32'd1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_input_framer.md
Name: fft_input_framer

Overview:
Upstream feeder for the 4-point FFT butterfly. Accepts a serial stream of 8-bit real samples over a valid/ready handshake and packs them into 4-sample frames. Frames are double-buffered in ping-pong banks. Each complete frame is presented as parallel x0..x3 with a start strobe held for a programmable number of cycles, covering the butterfly's two-register pipeline.

Parameters:
SAMPLE_W, 8, sample width; also width of x0..x3
START_CYCLES, 2, cycles start is held high per frame; legal range 1..15
CNT_W, 16, width of frame_count

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_data  input  SAMPLE_W  input sample
in_valid  input  1  in_data is valid
in_ready  output  1  framer can accept a sample this cycle
flush  input  1  zero-pad and close the current partial frame
x0, x1, x2, x3  output  SAMPLE_W each  frame samples, oldest sample in x0
start  output  1  frame strobe to the FFT
busy  output  1  a frame is being issued (state ISSUE or GAP)
frame_count  output  CNT_W  count of frames issued, wraps

Behaviour:
- Reset (asynchronous, reset_n low): every output goes to 0, including in_ready. Both bank full flags clear; wr_idx, wr_bank and rd_bank go to 0; state goes to IDLE. Reset mid-frame discards partial and pending frames, and start drops immediately.
- Storage: two banks of 4 x SAMPLE_W registers. Write side tracks wr_bank and wr_idx (0..3). Read side tracks rd_bank. Each bank has a full flag.
- in_ready = !full[wr_bank], decoded from registered state only, with no path from in_valid.
- Accept happens when in_valid && in_ready at a rising edge:
  - in_data is written to bank[wr_bank][wr_idx], then wr_idx increments.
  - If wr_idx was 3: set full[wr_bank], toggle wr_bank, and clear wr_idx to 0.
- Flush is sampled each edge:
  - If wr_idx != 0 and no frame completed on this edge: write zeros to slots wr_idx..3 (after storing any sample accepted this cycle), set full, toggle wr_bank, clear wr_idx.
  - If wr_idx == 0 after the accept (empty buffer, or the accept just completed a frame): flush is ignored.
- Issue FSM states are IDLE, ISSUE and GAP:
  - IDLE: if full[rd_bank], load x0..x3 from bank[rd_bank] slots 0..3, set start=1, clear cnt, go to ISSUE.
  - ISSUE: x0..x3 are held stable and start stays 1. cnt increments each cycle. When cnt == START_CYCLES-1: clear full[rd_bank], toggle rd_bank, increment frame_count, set start=0, go to GAP.
  - GAP: one cycle with start=0, then go to IDLE. This guarantees a low cycle between back-to-back frames.
- Latency: the 4th sample is accepted at edge k. x0..x3 and start are valid after edge k+1. start is high for exactly START_CYCLES cycles. The earliest next frame's start rises after edge k+START_CYCLES+3.
- x0..x3 keep the last issued frame's values while idle.
- Simultaneous set and clear of full flags always target different banks (write bank is never full, read bank always is). Both updates apply on the same edge.
- Throughput: with both banks full, in_ready is low until the ISSUE→GAP edge frees rd_bank. No sample is ever dropped or overwritten.
- frame_count wraps from all-ones to 0 with no flag.

Decomposition:
- Shared package fft_pkg holds:
  - SAMPLE_W
  - FFT_N = 4
  - issue-state encoding (IDLE=2'd0, ISSUE=2'd1, GAP=2'd2)
  - width constant for the 2-bit index
- One natural sub-module, fft_frame_bank, instantiated twice:
  - contents: a 4 x SAMPLE_W register array
  - ports: write enable, write index, write data, zero-pad-from-index, parallel read out
- The top level owns the handshake, the full flags and the issue FSM.

Test Plan:
- Basic frame: after reset, stream 8'h01,02,03,04 back-to-back → x0..x3 = 01,02,03,04, start high for exactly 2 cycles starting one cycle after the 4th accept, frame_count = 1.
- Back-to-back: stream 12 samples with in_valid held high (10..1B) → three frames in order, with exactly one start-low cycle between frames and in_ready dropping whenever both banks are full. No sample is lost: x values match the input order and frame_count = 3.
- Flush: send 8'hAA,8'hBB then pulse flush → frame AA,BB,00,00 is issued. Flush with an empty buffer → no frame issued and frame_count unchanged.
- Flush on completing accept: flush asserted on the same cycle as the 4th sample (8'h55) → single frame x3 = 55, with no extra zero frame.
- Reset mid-issue: assert reset_n low while start=1 → start, in_ready and frame_count = 0 immediately. After release, the partial frame is gone and a fresh 4-sample frame issues normally.
- Wrap and parameters: force frame_count to 16'hFFFF then issue one frame → frame_count = 0. With START_CYCLES=1 → start is a single-cycle pulse.
